// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation select and controller states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: one shift-add multiply step or one restoring-divide step per enable.
module seq_alu_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  // hi holds partial product / remainder; lo holds multiplier / dividend-then-quotient.
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             div_q;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

  always_comb begin
    add_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi  = add_s[WIDTH:1];
    mul_lo  = {add_s[0], lo_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so a non-negative trial always fits WIDTH bits.
    shifted = {hi_q, lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (!trial[WIDTH]) begin
      div_hi = trial[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi = shifted[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b0};
    end

    hi_nxt = div_q ? div_hi : mul_hi;
    lo_nxt = div_q ? div_lo : mul_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= is_div ? a : b;
      opnd_q <= is_div ? b : a;
      div_q  <= is_div;
    end else if (step) begin
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU (add/sub/mul/div) with valid/ready on both operand intake and result delivery.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               c
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               c_q, c_d;

  logic               iter_load, iter_step, iter_div;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic [WIDTH:0]     sum, diff;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (iter_load),
    .step   (iter_step),
    .is_div (iter_div),
    .a      (A),
    .b      (B),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    c_d       = c_q;
    iter_load = 1'b0;
    iter_step = 1'b0;
    iter_div  = (ctrl == OP_DIV);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op_e'(ctrl))
            OP_ADD: begin
              y_d     = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
              c_d     = sum[WIDTH];
              state_d = S_DONE;
            end
            OP_SUB: begin
              y_d     = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
              c_d     = diff[WIDTH];
              state_d = S_DONE;
            end
            OP_MUL: begin
              iter_load = 1'b1;
              cnt_d     = CNT_W'(WIDTH);
              state_d   = S_BUSY;
            end
            default: begin
              if (B == '0) begin
                y_d     = {A, {WIDTH{1'b1}}};
                c_d     = 1'b1;
                state_d = S_DONE;
              end else begin
                iter_load = 1'b1;
                cnt_d     = CNT_W'(WIDTH);
                state_d   = S_BUSY;
              end
            end
          endcase
        end
      end
      S_BUSY: begin
        iter_step = 1'b1;
        cnt_d     = cnt_q - 1'b1;
        // Capture the final iteration's result as it is computed.
        if (cnt_q == CNT_W'(1)) begin
          y_d     = {hi_nxt, lo_nxt};
          c_d     = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      c_q     <= c_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign c         = c_q;

endmodule
